// File: rtl/down_counter_ctrl_if.sv
// down_counter_ctrl_if: requester and counter-datapath signals of the down counter controller
interface down_counter_ctrl_if #(
  parameter int W      = 3,
  parameter int REPS_W = 4
);
  logic              start;
  logic [W-1:0]      cfg_load;
  logic [REPS_W-1:0] cfg_reps;
  logic              cfg_periodic;
  logic              abort;
  logic              done_ack;
  logic [W-1:0]      cnt_val;
  logic              cnt_load;
  logic [W-1:0]      cnt_load_val;
  logic              cnt_en;
  logic              tick;
  logic              busy;
  logic              done;
  logic              err;
  logic [REPS_W-1:0] reps_left;
  modport slave (
    input  start, cfg_load, cfg_reps, cfg_periodic, abort, done_ack, cnt_val,
    output cnt_load, cnt_load_val, cnt_en, tick, busy, done, err, reps_left
  );
  modport master (
    output start, cfg_load, cfg_reps, cfg_periodic, abort, done_ack, cnt_val,
    input  cnt_load, cnt_load_val, cnt_en, tick, busy, done, err, reps_left
  );
endinterface

// File: rtl/down_counter_ctrl.sv
// down_counter_ctrl: sequences load/enable of an external down counter over repeated or periodic passes
module down_counter_ctrl #(
  parameter int W      = 3,
  parameter int REPS_W = 4
) (
  input logic               c,
  input logic               r,
  down_counter_ctrl_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;
  state_t            r_state;
  state_t            w_next;
  logic [W-1:0]      r_l;
  logic              r_p;
  logic [REPS_W-1:0] r_reps;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic              w_load;
  logic              w_en;
  logic              w_tick;
  logic              w_accept;
  logic              w_reject;
  logic              w_abort;
  assign w_abort          = bus.abort && (r_state == S_LOAD || r_state == S_RUN);
  assign bus.cnt_load     = w_load;
  assign bus.cnt_load_val = r_l;
  assign bus.cnt_en       = w_en;
  assign bus.tick         = w_tick;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.err          = r_err;
  assign bus.reps_left    = r_reps;
  // state register
  always_ff @(posedge c or negedge r)
    if (!r) r_state <= S_IDLE;
    else    r_state <= w_next;
  // next state and counter strobes; abort masks the strobes and wins over zero-detect
  always_comb begin
    w_next   = r_state;
    w_load   = 1'b0;
    w_en     = 1'b0;
    w_tick   = 1'b0;
    w_accept = 1'b0;
    w_reject = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_reject = bus.start && (bus.cfg_load == '0);
        w_accept = bus.start && (bus.cfg_load != '0);
        w_next   = w_accept ? S_LOAD : S_IDLE;
      end
      S_LOAD: begin
        w_load = !bus.abort;
        w_next = bus.abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        w_en   = !bus.abort && (bus.cnt_val != '0);
        w_tick = !bus.abort && (bus.cnt_val == '0);
        w_next = bus.abort ? S_IDLE
               : !w_tick ? S_RUN
               : (r_p || r_reps > REPS_W'(1)) ? S_LOAD : S_DONE;
      end
      S_DONE: w_next = bus.done_ack ? S_IDLE : S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // captured configuration, pass count and registered status flags
  always_ff @(posedge c or negedge r)
    if (!r) begin
      r_l    <= '0;
      r_p    <= 1'b0;
      r_reps <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= (w_next == S_LOAD) || (w_next == S_RUN);
      r_done <= (w_next == S_DONE);
      r_err  <= w_reject;
      if (w_accept) begin
        r_l    <= bus.cfg_load;
        r_p    <= bus.cfg_periodic;
        r_reps <= (bus.cfg_reps == '0) ? REPS_W'(1) : bus.cfg_reps;
      end else if (w_abort) r_reps <= '0;
      else if (w_tick && !r_p) r_reps <= r_reps - REPS_W'(1);
    end
endmodule

// File: tb/tb_down_counter_ctrl.sv
// tb_down_counter_ctrl: directed checks of the controller driving a behavioural 3-bit down counter
module tb_down_counter_ctrl;
  logic c = 1'b0;
  logic r = 1'b0;
  logic [2:0] cnt;
  int total = 0;
  int bad = 0;
  int ntick, nload, ndone;
  int t_at[8];
  int rl_at[8];
  down_counter_ctrl_if #(.W(3), .REPS_W(4)) bus ();
  down_counter_ctrl #(.W(3), .REPS_W(4)) dut (.c(c), .r(r), .bus(bus));
  always #5 c = ~c;
  // external counter datapath
  always_ff @(posedge c or negedge r)
    if (!r) cnt <= '0;
    else if (bus.cnt_load) cnt <= bus.cnt_load_val;
    else if (bus.cnt_en) cnt <= cnt - 3'd1;
  assign bus.cnt_val = cnt;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge c);
    #1;
  endtask
  task automatic go(input int l, input int reps, input bit p);
    bus.start        = 1'b1;
    bus.cfg_load     = 3'(l);
    bus.cfg_reps     = 4'(reps);
    bus.cfg_periodic = p;
  endtask
  task automatic watch(input int n, input int again_at, input int abort_at);
    ntick = 0;
    nload = 0;
    ndone = 0;
    for (int i = 1; i <= n; i++) begin
      @(posedge c);
      #1;
      if (i == 1) begin
        bus.cfg_load     = 3'd5;
        bus.cfg_reps     = 4'd7;
        bus.cfg_periodic = 1'b0;
      end
      bus.start = (i == again_at);
      bus.abort = (i == abort_at);
      #1;
      if (i == abort_at) begin
        chk("abort_tick", bus.tick, 0);
        chk("abort_en", bus.cnt_en, 0);
        chk("abort_load", bus.cnt_load, 0);
      end
      if (bus.tick) begin
        if (ntick < 8) begin
          t_at[ntick]  = i;
          rl_at[ntick] = bus.reps_left;
        end
        ntick++;
      end
      if (bus.cnt_load) nload++;
      if (bus.done) ndone++;
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
  endtask
  initial begin
    bus.start = 0; bus.cfg_load = 0; bus.cfg_reps = 0; bus.cfg_periodic = 0;
    bus.abort = 0; bus.done_ack = 0;
    cyc(); cyc();
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_reps", bus.reps_left, 0);
    chk("rst_load", bus.cnt_load, 0);
    chk("rst_en", bus.cnt_en, 0);
    #2 r = 1'b1;
    // reset during the third RUN cycle
    cyc();
    go(5, 1, 0);
    cyc();
    bus.start = 0;
    cyc(); cyc(); cyc();
    chk("mid_en_before", bus.cnt_en, 1);
    chk("mid_cnt", cnt, 3);
    #2 r = 1'b0;
    #1;
    chk("mid_en", bus.cnt_en, 0);
    chk("mid_busy", bus.busy, 0);
    chk("mid_tick", bus.tick, 0);
    chk("mid_reps", bus.reps_left, 0);
    cyc();
    #2 r = 1'b1;
    cyc();
    chk("mid_idle_busy", bus.busy, 0);
    // one-shot L=3
    go(3, 1, 0);
    cyc();
    bus.start = 0;
    chk("os_load", bus.cnt_load, 1);
    chk("os_load_val", bus.cnt_load_val, 3);
    chk("os_load_en", bus.cnt_en, 0);
    chk("os_busy", bus.busy, 1);
    chk("os_reps", bus.reps_left, 1);
    for (int k = 3; k >= 1; k--) begin
      cyc();
      chk("os_run_en", bus.cnt_en, 1);
      chk("os_run_cnt", cnt, k);
      chk("os_run_load", bus.cnt_load, 0);
    end
    cyc();
    chk("os_tick", bus.tick, 1);
    chk("os_tick_en", bus.cnt_en, 0);
    cyc();
    chk("os_done", bus.done, 1);
    chk("os_done_busy", bus.busy, 0);
    chk("os_done_reps", bus.reps_left, 0);
    chk("os_done_tick", bus.tick, 0);
    // handshake hold with ignored start, abort and stray inputs in DONE
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      bus.start = (k == 3);
      bus.cfg_load = 3'd0;
      bus.abort = (k == 5);
      cyc();
      if (bus.done && !bus.busy && !bus.err) ndone++;
    end
    bus.start = 0;
    bus.abort = 0;
    chk("hold_done", ndone, 10);
    bus.done_ack = 1;
    cyc();
    bus.done_ack = 0;
    chk("ack_done", bus.done, 0);
    chk("ack_busy", bus.busy, 0);
    // multi-pass L=2 reps=3, started in the first IDLE cycle, with a stray start mid-run
    go(2, 3, 0);
    watch(13, 6, 0);
    chk("mp_ticks", ntick, 3);
    chk("mp_t0", t_at[0], 4);
    chk("mp_t1", t_at[1], 8);
    chk("mp_t2", t_at[2], 12);
    chk("mp_rl0", rl_at[0], 3);
    chk("mp_rl1", rl_at[1], 2);
    chk("mp_rl2", rl_at[2], 1);
    chk("mp_loads", nload, 3);
    chk("mp_done", bus.done, 1);
    chk("mp_reps_end", bus.reps_left, 0);
    chk("mp_lval", bus.cnt_load_val, 2);
    bus.done_ack = 1;
    cyc();
    bus.done_ack = 0;
    chk("mp_idle", bus.done, 0);
    // done_ack outside DONE does nothing
    bus.done_ack = 1;
    cyc();
    bus.done_ack = 0;
    chk("stray_ack_busy", bus.busy, 0);
    // zero reps means one pass, L=1
    go(1, 0, 0);
    watch(4, 0, 0);
    chk("z_ticks", ntick, 1);
    chk("z_t0", t_at[0], 3);
    chk("z_rl", rl_at[0], 1);
    chk("z_done", bus.done, 1);
    bus.done_ack = 1;
    cyc();
    bus.done_ack = 0;
    // rejected start
    go(0, 2, 0);
    cyc();
    bus.start = 0;
    chk("rej_err", bus.err, 1);
    chk("rej_busy", bus.busy, 0);
    cyc();
    chk("rej_err_end", bus.err, 0);
    chk("rej_busy_end", bus.busy, 0);
    // periodic L=7, abort on second zero-detect
    go(7, 2, 1);
    watch(19, 0, 18);
    chk("per_ticks", ntick, 1);
    chk("per_t0", t_at[0], 9);
    chk("per_rl0", rl_at[0], 2);
    chk("per_loads", nload, 2);
    chk("per_done", ndone, 0);
    chk("per_busy", bus.busy, 0);
    chk("per_reps", bus.reps_left, 0);
    // abort in LOAD then immediate restart
    go(4, 1, 0);
    cyc();
    bus.start = 0;
    bus.abort = 1;
    #1;
    chk("ab_load_strobe", bus.cnt_load, 0);
    cyc();
    bus.abort = 0;
    chk("ab_load_busy", bus.busy, 0);
    chk("ab_load_reps", bus.reps_left, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL timeout: got=1 exp=0");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/down_counter_ctrl.md
Name: down_counter_ctrl

Overview:
- Sequencing controller for the 3-bit synchronous down counter (sdown_counter-style datapath: load, enable, count value).
- Accepts a start request with a load value and repetition count, loads the counter and enables it until it reaches zero.
- Reloads for further repetitions, or forever in periodic mode, then signals completion through a done/ack handshake.
- Sits between software/FSM requesters and the counter datapath; the counter itself is external.

Parameters:
- W, 3, counter width; must match the counter datapath.
- REPS_W, 4, width of the repetition count.

Ports:
- c  input  1  clock; all state changes on rising edge.
- r  input  1  reset, asynchronous, active-low.
- start  input  1  request pulse; sampled only in IDLE.
- cfg_load  input  W  counter reload value; captured on accepted start.
- cfg_reps  input  REPS_W  number of count-down passes; captured on accepted start.
- cfg_periodic  input  1  1 = reload indefinitely until abort; captured on accepted start.
- abort  input  1  cancel the active sequence.
- done_ack  input  1  acknowledge for done.
- cnt_val  input  W  current counter value from the datapath.
- cnt_load  output  1  counter load strobe.
- cnt_load_val  output  W  value to load; equals captured L.
- cnt_en  output  1  counter decrement enable.
- tick  output  1  one-cycle pulse per pass reaching zero.
- busy  output  1  high in LOAD and RUN.
- done  output  1  high in DONE until acknowledged.
- err  output  1  one-cycle pulse when start is rejected.
- reps_left  output  REPS_W  remaining passes, including the current one.

Behaviour:
- Reset (r=0, asynchronous):
  - State goes to IDLE and all captured registers clear.
  - cnt_load, cnt_en, tick, busy, done, err and reps_left are all 0 immediately, without waiting for a clock edge.
- States: IDLE, LOAD, RUN, DONE. Encoding is free.
- IDLE, start=1:
  - cfg_load=0: start is rejected; err pulses for 1 cycle and the controller stays in IDLE.
  - Otherwise, capture L=cfg_load, P=cfg_periodic, reps_left=(cfg_reps==0 ? 1 : cfg_reps); next state LOAD.
- LOAD:
  - cnt_load=1, cnt_load_val=L, cnt_en=0 for exactly 1 cycle; next state RUN.
- RUN:
  - cnt_en = (cnt_val != 0), combinational.
  - When cnt_val==0: tick=1 for that cycle.
    - P=1: next state LOAD; reps_left unchanged.
    - P=0 and reps_left>1: reps_left decrements; next state LOAD.
    - P=0 and reps_left==1: reps_left becomes 0; next state DONE.
- Timing:
  - The counter reads L on the first RUN cycle.
  - Tick spacing is exactly L+2 cycles: 1 LOAD cycle plus L+1 RUN cycles.
  - First tick occurs L+2 cycles after the start edge.
- DONE:
  - done=1 and busy=0, held until done_ack=1, then IDLE on the next edge.
  - start is ignored in DONE, with no err pulse.
- abort in LOAD or RUN:
  - Next state IDLE; reps_left clears; done is not asserted.
  - In the abort cycle, cnt_load, cnt_en and tick are forced to 0. abort has priority over a coincident zero-detect.
- abort in IDLE or DONE has no effect; DONE still requires done_ack.
- start while busy is ignored; captured configuration does not change mid-sequence.
- done_ack outside DONE has no effect.
- Output timing: busy, done and reps_left are registered. cnt_load, cnt_load_val, cnt_en and tick are decoded combinationally from state and cnt_val.
- cnt_val changing outside RUN has no effect.

Test Plan:
- Reset mid-RUN:
  - Stimulus: L=5, reps=1; assert r=0 on the 3rd RUN cycle, between clock edges.
  - Required: cnt_en, busy and tick drop to 0 immediately; state IDLE after release; a subsequent start works normally.
- One-shot:
  - Stimulus: L=3, reps=1.
  - Required: cnt_load high 1 cycle with cnt_load_val=3; cnt_en high while cnt_val=3,2,1; tick at cnt_val=0, 5 cycles after start; done then held until done_ack, then busy=0 and done=0.
- Multi-pass:
  - Stimulus: L=2, reps=3.
  - Required: 3 ticks, each 4 cycles apart; reps_left reads 3, 2, 1, then 0 at DONE; 3 cnt_load pulses total.
- Periodic with abort:
  - Stimulus: L=7, P=1; abort on the same cycle as the 2nd zero-detect.
  - Required: exactly 1 tick observed; IDLE next cycle; no done; reps_left=0.
- Rejects and ignores:
  - Stimulus: start with cfg_load=0.
    - Required: err pulse, stays IDLE.
  - Stimulus: cfg_reps=0, L=1.
    - Required: treated as 1 pass; tick 3 cycles after start, then DONE.
  - Stimulus: start pulses during RUN and DONE.
    - Required: ignored; L and reps unchanged.
- Handshake hold:
  - Stimulus: withhold done_ack 10 cycles, then pulse it.
  - Required: done steady for those 10 cycles; IDLE one edge after done_ack; a start in that same IDLE cycle is accepted.
